// File: rtl/haar_pkg.sv
// Shared types and default constants for the Haar rectangle scheduler.
// Widths here mirror the scheduler's default parameterisation.
package haar_pkg;

    localparam int HAAR_W_DATA    = 18;
    localparam int HAAR_W_WEIGHT  = 3;
    localparam int HAAR_W_COORD   = 5;
    localparam int HAAR_MAX_RECTS = 3;
    localparam int HAAR_STRIDE    = 25;
    localparam int HAAR_W_ADDR    = 10;

    typedef struct packed {
        logic [HAAR_W_COORD-1:0]         x;
        logic [HAAR_W_COORD-1:0]         y;
        logic [HAAR_W_COORD-1:0]         w;
        logic [HAAR_W_COORD-1:0]         h;
        logic signed [HAAR_W_WEIGHT-1:0] weight;
    } rect_t;

    typedef enum logic [1:0] {CORNER_A, CORNER_B, CORNER_D, CORNER_C} corner_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} sched_state_t;

    // Offset of a rectangle corner from the window origin, full 32-bit width.
    function automatic logic [31:0] corner_offset(input corner_t c,
                                                  input logic [31:0] x, input logic [31:0] y,
                                                  input logic [31:0] w, input logic [31:0] h,
                                                  input logic [31:0] stride);
        logic [31:0] top_row;
        logic [31:0] bot_row;
        top_row = y * stride + x;
        bot_row = (y + h) * stride + x;
        case (c)
            CORNER_A: return top_row;
            CORNER_B: return top_row + w;
            CORNER_D: return bot_row + w;
            default:  return bot_row;
        endcase
    endfunction

endpackage

// File: rtl/haar_rect_sched_skid.sv
// Two-entry fall-through valid/ready buffer: data passes straight through
// when empty and the consumer is ready, otherwise it is parked.
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic [W-1:0] mem_q [2];
    logic         rd_q;
    logic         wr_q;
    logic [1:0]   cnt_q;
    logic         empty;
    logic         push;
    logic         pop;

    assign empty     = (cnt_q == 2'd0);
    assign out_valid = !empty || in_valid;
    assign out_data  = empty ? in_data : mem_q[rd_q];
    assign push      = in_valid && !(empty && out_ready);
    assign pop       = !empty && out_ready;
    assign occupancy = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= in_data;
                wr_q        <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/haar_rect_sched.sv
// Issues four corner reads per rectangle of a Haar feature and streams the data
// in A,B,D,C order. Optional stall counter enabled by RECT_SCHED_PERF_EN.
module haar_rect_sched
    import haar_pkg::*;
#(
    parameter int W_DATA    = HAAR_W_DATA,
    parameter int W_WEIGHT  = HAAR_W_WEIGHT,
    parameter int W_COORD   = HAAR_W_COORD,
    parameter int MAX_RECTS = HAAR_MAX_RECTS,
    parameter int STRIDE    = HAAR_STRIDE,
    parameter int W_ADDR    = HAAR_W_ADDR
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      feat_valid,
    output logic                                      feat_ready,
    input  logic [1:0]                                feat_num_rects,
    input  logic [MAX_RECTS*(4*W_COORD+W_WEIGHT)-1:0] feat_rects,
    input  logic [W_ADDR-1:0]                         win_base,
    output logic                                      mem_rd_en,
    output logic [W_ADDR-1:0]                         mem_addr,
    input  logic [W_DATA-1:0]                         mem_rd_data,
    output logic                                      dout_valid,
    input  logic                                      dout_ready,
    output logic [W_DATA-1:0]                         dout_data,
    output logic [W_WEIGHT-1:0]                       dout_weight,
    output logic                                      dout_rect_last,
    output logic                                      dout_feat_last,
    output logic                                      busy
`ifdef RECT_SCHED_PERF_EN
    ,
    output logic [31:0]                               perf_stall_cnt
`endif
);

    localparam int W_RECT = 4*W_COORD + W_WEIGHT;
    localparam int W_PAY  = W_DATA + W_WEIGHT + 2;

    sched_state_t                  state_q, state_d;
    corner_t                       corner_q;
    logic [1:0]                    rect_q;
    logic [1:0]                    last_rect_q;
    logic [1:0]                    n_eff;
    logic [MAX_RECTS*W_RECT-1:0]   rects_q;
    logic [W_ADDR-1:0]             base_q;
    logic                          inflight_q;
    logic [W_WEIGHT-1:0]           tag_wt_q;
    logic                          tag_rl_q;
    logic                          tag_fl_q;
    logic [1:0]                    occ;
    logic [W_RECT-1:0]             cur;
    logic [W_COORD-1:0]            cx, cy, cw, ch;
    logic [W_WEIGHT-1:0]           cwt;
    logic                          accept;
    logic                          issue;
    logic                          last_corner;
    logic                          last_rect;
    logic                          out_hs;
    logic [W_PAY-1:0]              fifo_out;

    assign feat_ready  = (state_q == IDLE) && !rst;
    assign accept      = feat_valid && feat_ready;
    assign busy        = (state_q != IDLE);

    assign cur = rects_q[int'(rect_q)*W_RECT +: W_RECT];
    assign cwt = cur[W_WEIGHT-1:0];
    assign ch  = cur[W_WEIGHT +: W_COORD];
    assign cw  = cur[W_WEIGHT+W_COORD +: W_COORD];
    assign cy  = cur[W_WEIGHT+2*W_COORD +: W_COORD];
    assign cx  = cur[W_WEIGHT+3*W_COORD +: W_COORD];

    // Stored entries plus the read returning this cycle must leave room for one more.
    assign issue       = (state_q == ISSUE) && ((occ + {1'b0, inflight_q}) < 2'd2);
    assign last_corner = (corner_q == CORNER_C);
    assign last_rect   = (rect_q == last_rect_q);

    assign mem_rd_en = issue;
    assign mem_addr  = W_ADDR'(32'(base_q) +
                               corner_offset(corner_q, 32'(cx), 32'(cy), 32'(cw), 32'(ch), 32'(STRIDE)));

    always_comb begin
        n_eff = feat_num_rects;
        if (n_eff == 2'd0) n_eff = 2'd1;
        else if (int'(n_eff) > MAX_RECTS) n_eff = 2'(MAX_RECTS);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (issue && last_corner && last_rect) state_d = DRAIN;
            DRAIN:   if (out_hs && dout_feat_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            corner_q    <= CORNER_A;
            rect_q      <= '0;
            last_rect_q <= '0;
            rects_q     <= '0;
            base_q      <= '0;
            inflight_q  <= 1'b0;
            tag_wt_q    <= '0;
            tag_rl_q    <= 1'b0;
            tag_fl_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                tag_wt_q <= cwt;
                tag_rl_q <= last_corner;
                tag_fl_q <= last_corner && last_rect;
                corner_q <= last_corner ? CORNER_A : corner_t'(corner_q + 2'd1);
                if (last_corner) rect_q <= rect_q + 2'd1;
            end
            if (accept) begin
                rects_q     <= feat_rects;
                base_q      <= win_base;
                last_rect_q <= n_eff - 2'd1;
                corner_q    <= CORNER_A;
                rect_q      <= '0;
            end
        end
    end

    skid_fifo2 #(.W(W_PAY)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight_q),
        .in_data   ({mem_rd_data, tag_wt_q, tag_rl_q, tag_fl_q}),
        .out_valid (dout_valid),
        .out_ready (dout_ready),
        .out_data  (fifo_out),
        .occupancy (occ)
    );

    assign {dout_data, dout_weight, dout_rect_last, dout_feat_last} = fifo_out;
    assign out_hs = dout_valid && dout_ready;

`ifdef RECT_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_stall_cnt <= '0;
        else if (accept) perf_stall_cnt <= '0;
        else if (dout_valid && !dout_ready && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/haar_rect_sched.md
Name: haar_rect_sched

Overview:
Sequences one Haar feature through the rect_sum datapath. It accepts a feature descriptor of 1..MAX_RECTS rectangles and issues four corner reads per rectangle to the integral-image memory, which has a 1-cycle read latency. It forwards the returned data in rect_sum corner order (A, B, D, C, i.e. A - B + D - C) on a valid/ready stream, together with each rectangle's weight. It sits between the stage/feature walker and rect_sum.

Parameters:
- W_DATA, 18, integral-image word width.
- W_WEIGHT, 3, signed rectangle weight width.
- W_COORD, 5, width of each x/y/w/h field.
- MAX_RECTS, 3, maximum rectangles per feature.
- STRIDE, 25, integral-image row pitch in words (window width + 1).
- W_ADDR, 10, memory address width; must satisfy W_ADDR >= clog2(STRIDE*STRIDE).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- feat_valid  in  1  descriptor valid.
- feat_ready  out  1  descriptor accepted; high only in IDLE.
- feat_num_rects  in  2  rectangle count, 1..MAX_RECTS.
- feat_rects  in  MAX_RECTS*(4*W_COORD+W_WEIGHT)  per rect {x,y,w,h,weight}; rect 0 in the LSBs.
- win_base  in  W_ADDR  window origin address in the integral image.
- mem_rd_en  out  1  read strobe.
- mem_addr  out  W_ADDR  read address.
- mem_rd_data  in  W_DATA  read data, valid the cycle after mem_rd_en.
- dout_valid  out  1  corner data valid.
- dout_ready  in  1  rect_sum ready.
- dout_data  out  W_DATA  corner value.
- dout_weight  out  W_WEIGHT  weight of the current rectangle; stable for all 4 corners.
- dout_rect_last  out  1  high with corner C (4th) of each rectangle.
- dout_feat_last  out  1  high with corner C of the final rectangle.
- busy  out  1  high from descriptor accept until the final corner is handshaken.

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0, skid buffer empty, mem_rd_en=0, dout_valid=0, busy=0, feat_ready=0 during reset and 1 in IDLE after release.
- Descriptor handling: on feat_valid && feat_ready, register the descriptor and win_base; go to ISSUE. An input count of 0 is treated as 1; counts > MAX_RECTS are clamped to MAX_RECTS.
- Corner addresses for rectangle r, relative to win_base:
  - A = y*STRIDE + x
  - B = A + w
  - D = (y+h)*STRIDE + x + w
  - C = (y+h)*STRIDE + x
  - Compute at full width, truncate to W_ADDR; no bounds check.
- FSM:
  - IDLE -> ISSUE on accept.
  - ISSUE: issue one read per cycle while the credit rule allows; corner counter 0..3, then rect counter increments.
  - ISSUE -> DRAIN after the read of the last corner of the last rect.
  - DRAIN -> IDLE when the skid buffer is empty and the final corner has been handshaken.
- Credit rule: a 2-entry skid buffer holds returned data. Issue a read only if (buffer occupancy + reads in flight) < 2. This guarantees no data loss under any dout_ready pattern.
- Tags: weight, rect_last and feat_last are pipelined alongside each read and stored with the data in the buffer.
- Throughput: with dout_ready held high, one corner per cycle. First dout_valid appears 2 cycles after the accept cycle. A 3-rect feature completes in 12 output cycles and is back in IDLE at cycle 14.
- Stream rule: once asserted, dout_valid holds with stable payload until dout_ready.
- Reset mid-feature: immediate return to IDLE. In-flight reads are discarded and the buffer is cleared; the downstream consumer must also be reset.

Optional Feature:
- RECT_SCHED_PERF_EN
  - Defined: adds output perf_stall_cnt [31:0]. It counts cycles with dout_valid && !dout_ready, saturates at all-ones, and clears on reset and on each descriptor accept.
  - Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package haar_pkg:
  - rect_t struct {x, y, w, h, weight};
  - corner enum {A, B, D, C};
  - sched_state_t enum {IDLE, ISSUE, DRAIN};
  - STRIDE and width constants.
- Sub-module skid_fifo2: 2-entry valid/ready buffer, parameterised payload width, exposes occupancy.

Test Plan:
- 1 rect {x=2, y=3, w=4, h=5, wt=-1}, win_base=0, dout_ready=1 -> addrs 77, 81, 206, 202 in order; dout_weight=-1 on all 4; rect_last and feat_last on the 4th.
- 3 rects, win_base=100, dout_ready=1 -> 12 corners on consecutive cycles, each address offset by 100, rect_last every 4th, feat_last only on the 12th, busy low at cycle 14.
- Same 3-rect feature with dout_ready toggled randomly (50%) -> identical data sequence, no drop or duplicate, never more than 2 reads outstanding.
- feat_num_rects=0 -> processed as 1 rect; feat_num_rects=3 with MAX_RECTS=2 -> 8 corners.
- rst asserted after the 5th corner -> all outputs at reset values asynchronously; a new descriptor after release runs cleanly from corner A.
- With RECT_SCHED_PERF_EN, dout_ready held low for 7 cycles with data pending -> perf_stall_cnt=7; it clears to 0 on the next accept.
